rgb_uart_ctrl: RTL and testbench

Command controller between the UART receive/transmit byte interfaces and the RGB LED driver. Parses single-byte commands and one-byte arguments from the UART byte stream and sets per-channel PWM duty and LED enable. Returns a one-byte acknowledge per command over a valid/ready transmit handshake. Generates the three PWM lines that feed the RGB0PWM/RGB1PWM/RGB2PWM and RGBLEDEN inputs of the SB_RGBA_DRV primitive.

---
 rtl/rgb_uart_pkg.sv | 40 ++++
 rtl/rgb_pwm_gen.sv | 41 ++++
 rtl/rgb_uart_ctrl.sv | 154 +++++++++++++++
 tb/tb_rgb_uart_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_uart_pkg.sv
// Shared types and byte constants for the UART-driven RGB LED controller.
package rgb_uart_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ARG = 2'd1,
        ACK      = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } chan_t;

    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] CMD_G   = 8'h47;
    localparam logic [7:0] CMD_B   = 8'h42;
    localparam logic [7:0] CMD_ON  = 8'h31;
    localparam logic [7:0] CMD_OFF = 8'h30;

    localparam logic [7:0] ACK_OK  = 8'h4B;
    localparam logic [7:0] ACK_ERR = 8'h3F;
    localparam logic [7:0] ACK_TMO = 8'h54;

    function automatic logic is_chan_cmd(input logic [7:0] b);
        return (b == CMD_R) || (b == CMD_G) || (b == CMD_B);
    endfunction

    function automatic chan_t chan_of(input logic [7:0] b);
        chan_t c;
        case (b)
            CMD_G:   c = CH_G;
            CMD_B:   c = CH_B;
            default: c = CH_R;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rgb_pwm_gen.sv
// Three-channel PWM: one shared free-running counter, one registered comparator per channel.
module rgb_pwm_gen
    import rgb_uart_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                hw_clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty0_i,
    input  logic [PWM_BITS-1:0] duty1_i,
    input  logic [PWM_BITS-1:0] duty2_i,
    output logic                pwm0_o,
    output logic                pwm1_o,
    output logic                pwm2_o
);

    logic [PWM_BITS-1:0] cnt_q;
    logic                pwm0_q;
    logic                pwm1_q;
    logic                pwm2_q;

    // Duty 0 never exceeds the counter, so that channel stays low; all-ones is low only at the top count.
    always_ff @(posedge hw_clk) begin
        if (reset) begin
            cnt_q  <= '0;
            pwm0_q <= 1'b0;
            pwm1_q <= 1'b0;
            pwm2_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_q + PWM_BITS'(1);
            pwm0_q <= (cnt_q < duty0_i);
            pwm1_q <= (cnt_q < duty1_i);
            pwm2_q <= (cnt_q < duty2_i);
        end
    end

    assign pwm0_o = pwm0_q;
    assign pwm1_o = pwm1_q;
    assign pwm2_o = pwm2_q;

endmodule

// File: rtl/rgb_uart_ctrl.sv
// Byte-command parser: sets RGB duties and LED enable from UART bytes, returns one ack byte per command.
module rgb_uart_ctrl
    import rgb_uart_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int ARG_TIMEOUT = 1_000_000
) (
    input  logic       hw_clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       rgb0_pwm,
    output logic       rgb1_pwm,
    output logic       rgb2_pwm,
    output logic       led_en,
    output logic       rx_overrun,
    output state_t     dbg_state
);

    localparam int              TMO_W    = (ARG_TIMEOUT > 2) ? $clog2(ARG_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ARG_TIMEOUT - 1);

    state_t              state_q,   state_d;
    chan_t               chan_q,    chan_d;
    logic [TMO_W-1:0]    tmo_q,     tmo_d;
    logic [PWM_BITS-1:0] duty0_q,   duty0_d;
    logic [PWM_BITS-1:0] duty1_q,   duty1_d;
    logic [PWM_BITS-1:0] duty2_q,   duty2_d;
    logic                led_en_q,  led_en_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                ovr_q,     ovr_d;

    always_ff @(posedge hw_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            chan_q     <= CH_R;
            tmo_q      <= '0;
            duty0_q    <= '0;
            duty1_q    <= '0;
            duty2_q    <= '0;
            led_en_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            tmo_q      <= tmo_d;
            duty0_q    <= duty0_d;
            duty1_q    <= duty1_d;
            duty2_q    <= duty2_d;
            led_en_q   <= led_en_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            ovr_q      <= ovr_d;
        end
    end

    // tx handshake: tx_valid rises with tx_data loaded, both hold until a cycle with tx_valid && tx_ready;
    // the ack leaves on that edge. Bytes arriving while an ack is pending are dropped and flagged.
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        tmo_d      = tmo_q;
        duty0_d    = duty0_q;
        duty1_d    = duty1_q;
        duty2_d    = duty2_q;
        led_en_d   = led_en_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        ovr_d      = ovr_q;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (is_chan_cmd(rx_data)) begin
                        chan_d  = chan_of(rx_data);
                        tmo_d   = '0;
                        state_d = WAIT_ARG;
                    end else begin
                        tx_valid_d = 1'b1;
                        state_d    = ACK;
                        case (rx_data)
                            CMD_ON: begin
                                led_en_d  = 1'b1;
                                tx_data_d = ACK_OK;
                            end
                            CMD_OFF: begin
                                led_en_d  = 1'b0;
                                tx_data_d = ACK_OK;
                            end
                            default: tx_data_d = ACK_ERR;
                        endcase
                    end
                end
            end

            WAIT_ARG: begin
                if (rx_valid) begin
                    case (chan_q)
                        CH_G:    duty1_d = PWM_BITS'(rx_data);
                        CH_B:    duty2_d = PWM_BITS'(rx_data);
                        default: duty0_d = PWM_BITS'(rx_data);
                    endcase
                    tx_valid_d = 1'b1;
                    tx_data_d  = ACK_OK;
                    state_d    = ACK;
                end else if (tmo_q == TMO_LAST) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = ACK_TMO;
                    state_d    = ACK;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ACK: begin
                if (rx_valid) begin
                    ovr_d = 1'b1;
                end
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    rgb_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .hw_clk  (hw_clk),
        .reset   (reset),
        .duty0_i (duty0_q),
        .duty1_i (duty1_q),
        .duty2_i (duty2_q),
        .pwm0_o  (rgb0_pwm),
        .pwm1_o  (rgb1_pwm),
        .pwm2_o  (rgb2_pwm)
    );

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign led_en     = led_en_q;
    assign rx_overrun = ovr_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_rgb_uart_ctrl.sv
// Directed bench for rgb_uart_ctrl: command table plus hand-written timeout, overrun, reset and PWM-phase cases.
module tb_rgb_uart_ctrl;
    import rgb_uart_pkg::*;

    localparam int PWM_BITS    = 8;
    localparam int ARG_TIMEOUT = 50;

    logic       hw_clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_ready = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       rgb0_pwm, rgb1_pwm, rgb2_pwm;
    logic       led_en;
    logic       rx_overrun;
    state_t     dbg_state;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [PWM_BITS-1:0] tb_cnt;

    typedef struct {
        logic [7:0] cmd;
        bit         has_arg;
        logic [7:0] arg;
        logic [7:0] exp_ack;
        logic       exp_led;
        int         ch;
        int         exp_high;
    } vec_t;

    vec_t vecs[10];

    rgb_uart_ctrl #(
        .PWM_BITS    (PWM_BITS),
        .ARG_TIMEOUT (ARG_TIMEOUT)
    ) dut (
        .hw_clk     (hw_clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .rgb0_pwm   (rgb0_pwm),
        .rgb1_pwm   (rgb1_pwm),
        .rgb2_pwm   (rgb2_pwm),
        .led_en     (led_en),
        .rx_overrun (rx_overrun),
        .dbg_state  (dbg_state)
    );

    // clock/reset block; tb_cnt follows the free-running counter the PWM is defined against
    always #5 hw_clk = ~hw_clk;

    always @(posedge hw_clk) begin
        if (reset) tb_cnt <= '0;
        else       tb_cnt <= tb_cnt + PWM_BITS'(1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim_time=%0t limit=1000000", $time);
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge hw_clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge hw_clk);
        rx_valid = 1'b0;
    endtask

    // waits for tx_valid, compares against the scoreboard head, then accepts it for one cycle
    task automatic get_ack(input string nm, input int max_wait, output int waits);
        logic [7:0] exp;
        waits = 0;
        while (tx_valid !== 1'b1 && waits < max_wait) begin
            @(negedge hw_clk);
            waits++;
        end
        if (tx_valid !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: tx_valid=%b want=1 after %0d cycles", nm, tx_valid, waits);
            return;
        end
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_unexpected: tx_data=%0h want=no ack", nm, tx_data);
            exp = 8'h00;
        end else begin
            exp = exp_q.pop_front();
            check($sformatf("%s_data", nm), 32'(tx_data), 32'(exp));
        end
        tx_ready = 1'b1;
        @(negedge hw_clk);
        tx_ready = 1'b0;
        check($sformatf("%s_drop", nm), 32'(tx_valid), 32'(0));
        check($sformatf("%s_idle", nm), 32'(dbg_state), 32'(IDLE));
    endtask

    task automatic count_high(input int ch, output int n);
        n = 0;
        repeat (256) begin
            @(negedge hw_clk);
            case (ch)
                0:       n += int'(rgb0_pwm);
                1:       n += int'(rgb1_pwm);
                default: n += int'(rgb2_pwm);
            endcase
        end
    endtask

    initial begin
        int   w;
        int   n;
        logic stable;
        logic quiet;

        vecs[0] = '{CMD_R,   1'b1, 8'h80, ACK_OK,  1'b0,  0, 128};
        vecs[1] = '{CMD_ON,  1'b0, 8'h00, ACK_OK,  1'b1, -1,   0};
        vecs[2] = '{CMD_OFF, 1'b0, 8'h00, ACK_OK,  1'b0, -1,   0};
        vecs[3] = '{8'h5A,   1'b0, 8'h00, ACK_ERR, 1'b0,  0, 128};
        vecs[4] = '{CMD_ON,  1'b0, 8'h00, ACK_OK,  1'b1, -1,   0};
        vecs[5] = '{8'h5A,   1'b0, 8'h00, ACK_ERR, 1'b1,  0, 128};
        vecs[6] = '{CMD_B,   1'b1, 8'h00, ACK_OK,  1'b1,  2,   0};
        vecs[7] = '{CMD_R,   1'b1, 8'h01, ACK_OK,  1'b1,  0,   1};
        vecs[8] = '{CMD_R,   1'b1, 8'hFE, ACK_OK,  1'b1,  0, 254};
        vecs[9] = '{8'h72,   1'b0, 8'h00, ACK_ERR, 1'b1,  0, 254};

        reset = 1'b1;
        repeat (3) @(negedge hw_clk);
        check("reset_outs", 32'({tx_valid, tx_data, rgb0_pwm, rgb1_pwm, rgb2_pwm, led_en, rx_overrun}), 32'(0));
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        repeat (4) @(negedge hw_clk);
        check("post_reset_outs", 32'({tx_valid, rgb0_pwm, rgb1_pwm, rgb2_pwm, led_en, rx_overrun}), 32'(0));

        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(vecs[i].exp_ack);
            send_byte(vecs[i].cmd);
            if (vecs[i].has_arg) send_byte(vecs[i].arg);
            get_ack($sformatf("vec%0d", i), 4, w);
            check($sformatf("vec%0d_latency", i), 32'(w), 32'(0));
            check($sformatf("vec%0d_led", i), 32'(led_en), 32'(vecs[i].exp_led));
            if (vecs[i].ch >= 0) begin
                count_high(vecs[i].ch, n);
                check($sformatf("vec%0d_high", i), 32'(n), 32'(vecs[i].exp_high));
            end
        end

        // argument timeout: 'T' exactly ARG_TIMEOUT cycles after entering WAIT_ARG, green untouched
        exp_q.push_back(ACK_TMO);
        send_byte(CMD_G);
        get_ack("tmo", 200, w);
        check("tmo_cycles", 32'(w), 32'(ARG_TIMEOUT));
        count_high(1, n);
        check("tmo_green_high", 32'(n), 32'(0));
        exp_q.push_back(ACK_OK);
        send_byte(CMD_G);
        send_byte(8'hFF);
        get_ack("green_ff", 4, w);
        count_high(1, n);
        check("green_ff_high", 32'(n), 32'(255));

        // mid-period duty change on blue (0x00 -> 0xFF) with the counter at a known phase
        n = 0;
        while (tb_cnt !== 8'h70 && n < 600) begin
            @(negedge hw_clk);
            n++;
        end
        check("mid_sync_a", 32'(tb_cnt), 32'(8'h70));
        send_byte(CMD_B);
        n = 0;
        while (tb_cnt !== 8'h7E && n < 40) begin
            @(negedge hw_clk);
            n++;
        end
        check("mid_sync_b", 32'(tb_cnt), 32'(8'h7E));
        exp_q.push_back(ACK_OK);
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        @(negedge hw_clk);
        rx_valid = 1'b0;
        check("mid_old_duty", 32'(rgb2_pwm), 32'(0));
        @(negedge hw_clk);
        check("mid_new_duty", 32'(rgb2_pwm), 32'(1));
        get_ack("mid", 4, w);

        // ack held off for 20 cycles with a byte injected: ack stable, byte dropped, overrun sticky
        exp_q.push_back(ACK_OK);
        send_byte(CMD_B);
        send_byte(8'h10);
        check("ovr_pre", 32'(rx_overrun), 32'(0));
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (tx_valid !== 1'b1 || tx_data !== ACK_OK) stable = 1'b0;
            if (k == 5) begin
                rx_valid = 1'b1;
                rx_data  = CMD_OFF;
            end else begin
                rx_valid = 1'b0;
            end
            @(negedge hw_clk);
        end
        rx_valid = 1'b0;
        check("ovr_stable", 32'(stable), 32'(1));
        check("ovr_sticky", 32'(rx_overrun), 32'(1));
        check("ovr_state", 32'(dbg_state), 32'(ACK));
        check("ovr_led_kept", 32'(led_en), 32'(1));
        get_ack("ovr", 2, w);
        quiet = 1'b1;
        repeat (5) begin
            @(negedge hw_clk);
            if (tx_valid !== 1'b0) quiet = 1'b0;
        end
        check("ovr_single_ack", 32'(quiet), 32'(1));
        count_high(2, n);
        check("ovr_blue_high", 32'(n), 32'(16));
        check("ovr_still_set", 32'(rx_overrun), 32'(1));

        // reset in WAIT_ARG: no ack, next byte parsed as a command
        send_byte(CMD_R);
        reset = 1'b1;
        repeat (2) @(negedge hw_clk);
        reset = 1'b0;
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_outs", 32'({tx_valid, led_en, rx_overrun}), 32'(0));
        quiet = 1'b1;
        repeat (ARG_TIMEOUT + 10) begin
            @(negedge hw_clk);
            if (tx_valid !== 1'b0) quiet = 1'b0;
        end
        check("rst_no_ack", 32'(quiet), 32'(1));
        exp_q.push_back(ACK_ERR);
        send_byte(8'h40);
        get_ack("rst_cmd", 4, w);
        count_high(0, n);
        check("rst_red_high", 32'(n), 32'(0));
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
